// File: rtl/eth_txcounters_gen.sv
// Transmit symbol/byte/delayed-CRC counters for the Ethernet TX path, MII or GMII symbol mode.
// Counters saturate instead of wrapping; a registered length report accompanies every finished frame.
module eth_txcounters_gen #(
  parameter int CNT_W       = 16,
  parameter int DLY_W       = 3,
  parameter int DLY_CRC_LEN = 4,
  parameter int EXDEF_LIMIT = 6071
) (
  input  logic             MTxClk,
  input  logic             nReset,
  input  logic             GmiiMode,
  input  logic             StatePreamble,
  input  logic             StateIPG,
  input  logic             StatePAD,
  input  logic             StateFCS,
  input  logic             StateJam,
  input  logic             StateBackOff,
  input  logic             StateDefer,
  input  logic             StateIdle,
  input  logic             StateSFD,
  input  logic [1:0]       StateData,
  input  logic             StartDefer,
  input  logic             StartIPG,
  input  logic             StartFCS,
  input  logic             StartJam,
  input  logic             StartBackoff,
  input  logic             TxStartFrm,
  input  logic             HugEn,
  input  logic             ExDfrEn,
  input  logic             DlyCrcEn,
  input  logic             PacketFinished_q,
  input  logic [CNT_W-1:0] MinFL,
  input  logic [CNT_W-1:0] MaxFL,
  output logic [CNT_W-1:0] SymCnt,
  output logic [CNT_W-1:0] ByteCnt,
  output logic [DLY_W-1:0] DlyCrcCnt,
  output logic             ExcessiveDefer,
  output logic             PreambleDone,
  output logic             JamDone,
  output logic             MaxFrame,
  output logic             MinFlReached,
  output logic             ByteCntSat,
  output logic [CNT_W-1:0] FrmLen,
  output logic             FrmLenValid
);

  typedef logic [CNT_W:0] ext_t;

  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] EX_THR_MII  = CNT_W'(EXDEF_LIMIT);
  localparam logic [CNT_W-1:0] EX_THR_GMII = CNT_W'(EXDEF_LIMIT >> 1);
  localparam logic [DLY_W-1:0] DLY_END     = DLY_W'(DLY_CRC_LEN);

  logic             dataTick;
  logic [CNT_W-1:0] exThr;
  logic             symClr;
  logic             symInc;
  logic             byteClr;
  logic             byteInc;
  logic             dlyClr;
  logic             dlyInc;
  ext_t             minFlExt;
  ext_t             minFlThr;

  assign dataTick = GmiiMode ? (|StateData) : StateData[1];
  assign exThr    = GmiiMode ? EX_THR_GMII : EX_THR_MII;

  assign PreambleDone   = GmiiMode ? (SymCnt[2:0] == 3'd6) : (&SymCnt[3:0]);
  assign JamDone        = GmiiMode ? (&SymCnt[1:0]) : (&SymCnt[2:0]);
  assign ExcessiveDefer = (SymCnt == exThr) & ~ExDfrEn;
  assign MaxFrame       = (ByteCnt == MaxFL) & ~HugEn;

  // Threshold excludes the 4 FCS bytes; one extra bit keeps the subtraction from wrapping.
  assign minFlExt     = {1'b0, MinFL};
  assign minFlThr     = GmiiMode ? (minFlExt - ext_t'(5))
                                 : (((minFlExt - ext_t'(4)) << 1) - ext_t'(1));
  assign MinFlReached = (MinFL <= CNT_W'(4)) ? 1'b1 : ({1'b0, SymCnt} >= minFlThr);

  assign symClr = (StateDefer & ExcessiveDefer & ~TxStartFrm) | (StatePreamble & PreambleDone)
                | (StateJam & JamDone) | StateIdle | StartDefer | StartIPG | StartFCS | StartJam;
  assign symInc = StateIPG | StatePreamble | (|StateData) | StatePAD | StateFCS | StateJam
                | StateBackOff | (StateDefer & ~ExcessiveDefer & TxStartFrm);

  assign byteClr = StartBackoff | (StateIdle & TxStartFrm) | PacketFinished_q;
  assign byteInc = dataTick
                 | (StateBackOff & (GmiiMode ? (&SymCnt[5:0]) : (&SymCnt[6:0])))
                 | ((StatePAD | StateFCS) & (GmiiMode | SymCnt[0]));

  assign dlyClr = (dataTick & (DlyCrcCnt == DLY_END)) | StartJam | PacketFinished_q;
  assign dlyInc = DlyCrcEn & (StateSFD | (dataTick & (DlyCrcCnt != {DLY_W{1'b0}})));

  // Symbol counter, held at all-ones rather than wrapping.
  always_ff @(posedge MTxClk or negedge nReset) begin
    if (!nReset) begin
      SymCnt <= '0;
    end else if (symClr) begin
      SymCnt <= '0;
    end else if (symInc && (SymCnt != CNT_MAX)) begin
      SymCnt <= SymCnt + CNT_W'(1);
    end else begin
      SymCnt <= SymCnt;
    end
  end

  // Byte counter with sticky saturation flag; a clear drops both.
  always_ff @(posedge MTxClk or negedge nReset) begin
    if (!nReset) begin
      ByteCnt    <= '0;
      ByteCntSat <= 1'b0;
    end else if (byteClr) begin
      ByteCnt    <= '0;
      ByteCntSat <= 1'b0;
    end else if (byteInc) begin
      if (ByteCnt == CNT_MAX) begin
        ByteCnt    <= ByteCnt;
        ByteCntSat <= 1'b1;
      end else begin
        ByteCnt    <= ByteCnt + CNT_W'(1);
        ByteCntSat <= ByteCntSat;
      end
    end else begin
      ByteCnt    <= ByteCnt;
      ByteCntSat <= ByteCntSat;
    end
  end

  // Delayed-CRC counter.
  always_ff @(posedge MTxClk or negedge nReset) begin
    if (!nReset) begin
      DlyCrcCnt <= '0;
    end else if (dlyClr) begin
      DlyCrcCnt <= '0;
    end else if (dlyInc) begin
      DlyCrcCnt <= DlyCrcCnt + DLY_W'(1);
    end else begin
      DlyCrcCnt <= DlyCrcCnt;
    end
  end

  // Frame length report: captures the count before the clear lands.
  always_ff @(posedge MTxClk or negedge nReset) begin
    if (!nReset) begin
      FrmLen      <= '0;
      FrmLenValid <= 1'b0;
    end else begin
      FrmLenValid <= PacketFinished_q;
      if (PacketFinished_q) begin
        FrmLen <= ByteCnt;
      end else begin
        FrmLen <= FrmLen;
      end
    end
  end

endmodule

// File: tb/tb_eth_txcounters_gen.sv
// Randomized and directed bench for eth_txcounters_gen against an integer reference model.
module tb_eth_txcounters_gen;

  localparam int CNT_W  = 16;
  localparam int DLY_W  = 3;
  localparam int MAXCNT = (1 << CNT_W) - 1;

  logic MTxClk, nReset, GmiiMode;
  logic StatePreamble, StateIPG, StatePAD, StateFCS, StateJam, StateBackOff, StateDefer, StateIdle, StateSFD;
  logic [1:0] StateData;
  logic StartDefer, StartIPG, StartFCS, StartJam, StartBackoff;
  logic TxStartFrm, HugEn, ExDfrEn, DlyCrcEn, PacketFinished_q;
  logic [CNT_W-1:0] MinFL, MaxFL, SymCnt, ByteCnt, FrmLen;
  logic [DLY_W-1:0] DlyCrcCnt;
  logic ExcessiveDefer, PreambleDone, JamDone, MaxFrame, MinFlReached, ByteCntSat, FrmLenValid;

  int nChecks = 0;
  int nFails  = 0;
  int mSym, mByte, mDly, mFrmLen;
  bit mSat, mValid;

  eth_txcounters_gen dut (
    .MTxClk(MTxClk), .nReset(nReset), .GmiiMode(GmiiMode),
    .StatePreamble(StatePreamble), .StateIPG(StateIPG), .StatePAD(StatePAD), .StateFCS(StateFCS),
    .StateJam(StateJam), .StateBackOff(StateBackOff), .StateDefer(StateDefer), .StateIdle(StateIdle),
    .StateSFD(StateSFD), .StateData(StateData),
    .StartDefer(StartDefer), .StartIPG(StartIPG), .StartFCS(StartFCS), .StartJam(StartJam),
    .StartBackoff(StartBackoff), .TxStartFrm(TxStartFrm), .HugEn(HugEn), .ExDfrEn(ExDfrEn),
    .DlyCrcEn(DlyCrcEn), .PacketFinished_q(PacketFinished_q), .MinFL(MinFL), .MaxFL(MaxFL),
    .SymCnt(SymCnt), .ByteCnt(ByteCnt), .DlyCrcCnt(DlyCrcCnt), .ExcessiveDefer(ExcessiveDefer),
    .PreambleDone(PreambleDone), .JamDone(JamDone), .MaxFrame(MaxFrame), .MinFlReached(MinFlReached),
    .ByteCntSat(ByteCntSat), .FrmLen(FrmLen), .FrmLenValid(FrmLenValid)
  );

  initial MTxClk = 1'b0;
  always #5 MTxClk = ~MTxClk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit mExDef();
    return (mSym == (GmiiMode ? 3035 : 6071)) && !ExDfrEn;
  endfunction

  function automatic bit mPreDone();
    return GmiiMode ? (mSym % 8 == 6) : (mSym % 16 == 15);
  endfunction

  function automatic bit mJamDone();
    return GmiiMode ? (mSym % 4 == 3) : (mSym % 8 == 7);
  endfunction

  function automatic bit mMinFl();
    int minFl = int'(MinFL);
    if (minFl <= 4) return 1'b1;
    return mSym >= (GmiiMode ? minFl - 5 : 2 * (minFl - 4) - 1);
  endfunction

  task automatic checkAll();
    checkVal("SymCnt", SymCnt, mSym);
    checkVal("ByteCnt", ByteCnt, mByte);
    checkVal("DlyCrcCnt", DlyCrcCnt, mDly);
    checkVal("ByteCntSat", ByteCntSat, mSat);
    checkVal("FrmLen", FrmLen, mFrmLen);
    checkVal("FrmLenValid", FrmLenValid, mValid);
    checkVal("ExcessiveDefer", ExcessiveDefer, mExDef());
    checkVal("PreambleDone", PreambleDone, mPreDone());
    checkVal("JamDone", JamDone, mJamDone());
    checkVal("MinFlReached", MinFlReached, mMinFl());
    checkVal("MaxFrame", MaxFrame, (mByte == int'(MaxFL)) && !HugEn);
  endtask

  task automatic modelReset();
    mSym = 0; mByte = 0; mDly = 0; mFrmLen = 0; mSat = 0; mValid = 0;
  endtask

  // Advance one clock: derive next model state from the present inputs, then compare.
  task automatic tick();
    bit dataTick, symClr, symInc, byteClr, byteInc, dlyClr, dlyInc;
    int nSym, nByte, nDly, nFrm;
    bit nSat, nValid;
    dataTick = GmiiMode ? (StateData != 2'd0) : (StateData >= 2'd2);
    symClr = (StateDefer && mExDef() && !TxStartFrm) || (StatePreamble && mPreDone()) ||
             (StateJam && mJamDone()) || StateIdle || StartDefer || StartIPG || StartFCS || StartJam;
    symInc = StateIPG || StatePreamble || (StateData != 2'd0) || StatePAD || StateFCS || StateJam ||
             StateBackOff || (StateDefer && !mExDef() && TxStartFrm);
    nSym = symClr ? 0 : (symInc && mSym < MAXCNT) ? mSym + 1 : mSym;
    byteClr = StartBackoff || (StateIdle && TxStartFrm) || PacketFinished_q;
    byteInc = dataTick || (StateBackOff && (GmiiMode ? (mSym % 64 == 63) : (mSym % 128 == 127))) ||
              ((StatePAD || StateFCS) && (GmiiMode || (mSym % 2 == 1)));
    nByte = byteClr ? 0 : (byteInc && mByte < MAXCNT) ? mByte + 1 : mByte;
    nSat  = byteClr ? 1'b0 : (mSat || (byteInc && mByte == MAXCNT));
    dlyClr = (dataTick && mDly == 4) || StartJam || PacketFinished_q;
    dlyInc = DlyCrcEn && (StateSFD || (dataTick && mDly != 0));
    nDly = dlyClr ? 0 : dlyInc ? (mDly + 1) % 8 : mDly;
    nFrm   = PacketFinished_q ? mByte : mFrmLen;
    nValid = PacketFinished_q;
    @(posedge MTxClk);
    #1;
    if (!nReset) begin
      modelReset();
    end else begin
      mSym = nSym; mByte = nByte; mDly = nDly; mFrmLen = nFrm; mSat = nSat; mValid = nValid;
    end
    checkAll();
  endtask

  task automatic clearCtl();
    {StatePreamble, StateIPG, StatePAD, StateFCS, StateJam, StateBackOff, StateDefer, StateIdle, StateSFD} = 9'd0;
    StateData = 2'd0;
    {StartDefer, StartIPG, StartFCS, StartJam, StartBackoff} = 5'd0;
    {TxStartFrm, PacketFinished_q} = 2'd0;
  endtask

  task automatic goIdle(input bit gmii);
    clearCtl();
    StateIdle = 1'b1;
    GmiiMode  = gmii;
    TxStartFrm = 1'b1;
    tick();
    clearCtl();
  endtask

  initial begin
    nReset = 1'b0;
    GmiiMode = 1'b0;
    clearCtl();
    {HugEn, ExDfrEn, DlyCrcEn} = 3'd0;
    MinFL = 16'd64;
    MaxFL = 16'd1518;
    modelReset();
    #3;
    checkAll();
    @(posedge MTxClk); #1;
    nReset = 1'b1;

    // MII preamble and minimum-frame threshold
    goIdle(1'b0);
    StatePreamble = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    checkVal("pre_sym15", SymCnt, 32'd15);
    checkVal("pre_done", PreambleDone, 32'd1);
    tick();
    checkVal("pre_wrap", SymCnt, 32'd0);
    clearCtl();
    StateIdle = 1'b1; tick(); clearCtl();
    StateIPG = 1'b1;
    for (int i = 0; i < 118; i++) tick();
    checkVal("minfl_118", MinFlReached, 32'd0);
    tick();
    checkVal("minfl_119", MinFlReached, 32'd1);

    // GMII 60-byte frame and length report
    goIdle(1'b1);
    StateData = 2'b01;
    for (int i = 0; i < 60; i++) tick();
    checkVal("gmii_bytes", ByteCnt, 32'd60);
    clearCtl();
    PacketFinished_q = 1'b1;
    tick();
    checkVal("frmlen", FrmLen, 32'd60);
    checkVal("frmlen_valid", FrmLenValid, 32'd1);
    checkVal("byte_cleared", ByteCnt, 32'd0);
    clearCtl();
    tick();
    checkVal("frmlen_valid_drop", FrmLenValid, 32'd0);

    // Excessive deferral, MII then GMII
    goIdle(1'b0);
    StateDefer = 1'b1; TxStartFrm = 1'b1;
    for (int i = 0; i < 6100; i++) tick();
    checkVal("exdef_mii", SymCnt, 32'd6071);
    checkVal("exdef_mii_flag", ExcessiveDefer, 32'd1);
    goIdle(1'b1);
    StateDefer = 1'b1; TxStartFrm = 1'b1;
    for (int i = 0; i < 3100; i++) tick();
    checkVal("exdef_gmii", SymCnt, 32'd3035);
    checkVal("exdef_gmii_flag", ExcessiveDefer, 32'd1);

    // Byte counter saturation
    goIdle(1'b1);
    HugEn = 1'b1;
    StateData = 2'b01;
    for (int i = 0; i < MAXCNT; i++) tick();
    checkVal("sat_full", ByteCnt, MAXCNT);
    checkVal("sat_not_yet", ByteCntSat, 32'd0);
    tick(); tick();
    checkVal("sat_hold", ByteCnt, MAXCNT);
    checkVal("sat_flag", ByteCntSat, 32'd1);
    clearCtl();
    StartBackoff = 1'b1;
    tick();
    checkVal("sat_clr_cnt", ByteCnt, 32'd0);
    checkVal("sat_clr_flag", ByteCntSat, 32'd0);
    HugEn = 1'b0;

    // Delayed CRC counter, MII
    goIdle(1'b0);
    PacketFinished_q = 1'b1; tick(); clearCtl();
    DlyCrcEn = 1'b1;
    StateSFD = 1'b1; tick(); StateSFD = 1'b0;
    checkVal("dly_1", DlyCrcCnt, 32'd1);
    StateData = 2'b10;
    tick(); checkVal("dly_2", DlyCrcCnt, 32'd2);
    tick(); checkVal("dly_3", DlyCrcCnt, 32'd3);
    tick(); checkVal("dly_4", DlyCrcCnt, 32'd4);
    tick(); checkVal("dly_0", DlyCrcCnt, 32'd0);
    clearCtl();
    StateSFD = 1'b1; tick(); StateSFD = 1'b0;
    StateData = 2'b10; tick();
    checkVal("dly_jam_pre", DlyCrcCnt, 32'd2);
    StartJam = 1'b1; tick();
    checkVal("dly_jam", DlyCrcCnt, 32'd0);
    clearCtl();
    DlyCrcEn = 1'b0;

    // Reset mid-frame
    goIdle(1'b1);
    StateData = 2'b01;
    for (int i = 0; i < 30; i++) tick();
    checkVal("rst_pre", ByteCnt, 32'd30);
    #2;
    nReset = 1'b0;
    #1;
    modelReset();
    checkVal("rst_sym", SymCnt, 32'd0);
    checkVal("rst_byte", ByteCnt, 32'd0);
    checkVal("rst_frmlen", FrmLen, 32'd0);
    checkVal("rst_valid", FrmLenValid, 32'd0);
    checkAll();
    tick();
    nReset = 1'b1;
    clearCtl();
    StateIdle = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkVal("rst_no_valid", FrmLenValid, 32'd0);
    end

    // Randomized segments
    for (int seg = 0; seg < 400; seg++) begin
      int sel, len;
      clearCtl();
      sel = $urandom_range(0, 9);
      len = $urandom_range(1, 24);
      HugEn    = 1'($urandom_range(0, 1));
      ExDfrEn  = 1'($urandom_range(0, 1));
      DlyCrcEn = 1'($urandom_range(0, 1));
      MinFL    = 16'($urandom_range(0, 40));
      MaxFL    = 16'($urandom_range(0, 60));
      for (int c = 0; c < len; c++) begin
        clearCtl();
        case (sel)
          0: begin StateIdle = 1'b1; if (c == 0) GmiiMode = 1'($urandom_range(0, 1)); end
          1: StatePreamble = 1'b1;
          2: StateIPG = 1'b1;
          3: StatePAD = 1'b1;
          4: StateFCS = 1'b1;
          5: StateJam = 1'b1;
          6: StateBackOff = 1'b1;
          7: StateDefer = 1'b1;
          8: StateSFD = 1'b1;
          default: StateData = 2'($urandom_range(0, 3));
        endcase
        TxStartFrm       = ($urandom_range(0, 3) == 0);
        PacketFinished_q = ($urandom_range(0, 15) == 0);
        StartDefer       = ($urandom_range(0, 31) == 0);
        StartIPG         = ($urandom_range(0, 31) == 0);
        StartFCS         = ($urandom_range(0, 31) == 0);
        StartJam         = ($urandom_range(0, 31) == 0);
        StartBackoff     = ($urandom_range(0, 31) == 0);
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
